tx_mod: RTL
===========

Name: tx_mod

Overview:
UART transmitter, the companion of the UART receiver in the TP2-UART datapath. It shares the oversampling tick (16 ticks per bit) from the common baud-rate generator. On a start request it latches one data word and serialises it LSB-first: start bit, NB_DATA data bits, optional parity bit, then stop period. It pulses a done tick when the frame ends and sits between the interface/ALU controller and the physical tx line.

Parameters:
NB_DATA, 8, data bits per frame (5..8).
STOP_TICKS, 16, stop-period length in s_ticks (16/24/32 = 1/1.5/2 stop bits; max 32).
PARITY_EN, 0, 1 = append parity bit after data.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_reset  input  1  synchronous, active-high reset.
i_s_tick  input  1  one-cycle oversampling tick, 16 per bit period.
i_tx_start  input  1  request to send i_tx_data; sampled only in IDLE.
i_tx_data  input  NB_DATA  word to send; latched on accepted start.
o_tx  output  1  serial line, idle high.
o_tx_busy  output  1  high while a frame is in progress (any state other than IDLE).
o_tx_done_tick  output  1  one-cycle pulse at end of stop period.

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_reset); no asynchronous logic.
- Reset values: state=IDLE, tick counter=0, bit counter=0, shift reg=0, o_tx=1 (registered), o_tx_busy=0, o_tx_done_tick=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1. If i_tx_start=1 on cycle N, latch i_tx_data into shift reg, compute parity (XOR of data, inverted when PARITY_ODD), clear counters, go to START. o_tx=0 and o_tx_busy=1 from cycle N+1.
- START: o_tx=0. Increment tick counter on each i_s_tick. On the i_s_tick with counter==15, clear counter, go to DATA with bit counter=0.
- DATA: o_tx=shift[0]. On the i_s_tick with counter==15, clear counter, shift right by 1. If bit counter==NB_DATA-1, go to PARITY when PARITY_EN=1, else to STOP. Otherwise increment bit counter.
- PARITY: o_tx=parity bit. Last for 16 ticks, then go to STOP.
- STOP: o_tx=1. On the i_s_tick with counter==STOP_TICKS-1, clear counter, assert o_tx_done_tick for exactly that cycle, and go to IDLE.
- o_tx_busy deasserts the cycle after the done tick.
- Each bit lasts exactly 16 i_s_ticks, and the stop period exactly STOP_TICKS ticks, regardless of the clock/tick ratio.
- Counters advance only on i_s_tick. Cycles without a tick hold all state.
- The tick counter is 5 bits wide and must not wrap before STOP_TICKS-1.
- i_tx_start while busy is ignored (no queueing). i_tx_data changes after latch do not affect the frame.
- i_tx_start asserted on the same cycle as o_tx_done_tick is ignored. It is accepted on the next cycle in IDLE, so back-to-back frames have a minimum one-cycle idle gap.
- o_tx is registered and glitch-free. It is driven from next-state/next-bit logic so the line changes one cycle after the deciding edge.
- Reset mid-frame: the next cycle o_tx=1, state IDLE, busy=0, no done tick. Any partial frame is abandoned.
- i_tx_start and i_reset in the same cycle: reset wins.

Decomposition:
- Shared package (uart_pkg): state encodings, TICKS_PER_BIT=16, and the tick-counter width constant. The receiver uses the same package.
- No sub-module inside tx_mod.
- The tick source is the existing shared baud-rate generator, instantiated at the UART top, not inside this block.

Test Plan:
- NB_DATA=8, no parity, i_tx_start with 0x55, tick every 4 clocks -> o_tx shows 0,1,0,1,0,1,0,1,0,1. Each level lasts 16 ticks (64 clocks). One done pulse after 16 stop ticks; busy high for 160 ticks.
- PARITY_EN=1, PARITY_ODD=0, data 0x07 -> bits 1,1,1,0,0,0,0,0 then parity=1, then stop. With PARITY_ODD=1 -> parity=0.
- STOP_TICKS=32, data 0xA3 -> stop period exactly 32 ticks high before the done pulse. Counter must not wrap early.
- i_tx_start pulsed with 0xFF during the DATA phase of a 0x00 frame -> line carries only 0x00. The second request is dropped and only one done pulse occurs.
- i_reset asserted mid-DATA (bit 3) -> o_tx=1 and busy=0 on the next cycle, no done tick. A following start with 0x3C transmits correctly.
- Start held high continuously with 0x81 -> frames separated by exactly 1 idle cycle after each done pulse. Each frame decodes as 0x81 in a loopback to rx_mod.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmitter and receiver.
// Both sides oversample each bit 16 times and use a 5-bit tick counter.
package uart_pkg;

   localparam int TICKS_PER_BIT = 16;
   localparam int TICK_CNT_W    = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

endpackage

// File: rtl/tx_mod.sv
// UART transmitter: start bit, LSB-first data, optional parity, then the stop period.
// Bit timing comes from the shared 16x oversampling tick.
module tx_mod
   import uart_pkg::*;
#(
   parameter int NB_DATA    = 8,
   parameter int STOP_TICKS = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_s_tick,
   input  logic               i_tx_start,
   input  logic [NB_DATA-1:0] i_tx_data,
   output logic               o_tx,
   output logic               o_tx_busy,
   output logic               o_tx_done_tick
);

   localparam logic [TICK_CNT_W-1:0] BIT_LAST  = TICK_CNT_W'(TICKS_PER_BIT - 1);
   localparam logic [TICK_CNT_W-1:0] STOP_LAST = TICK_CNT_W'(STOP_TICKS - 1);
   localparam logic [2:0]            DATA_LAST = 3'(NB_DATA - 1);
   localparam logic                  ODD       = (PARITY_ODD != 0);

   uart_state_t             state_reg, state_next;
   logic [TICK_CNT_W-1:0]   tick_reg, tick_next;
   logic [2:0]              bit_reg, bit_next;
   logic [NB_DATA-1:0]      shift_reg, shift_next;
   logic                    parity_reg, parity_next;
   logic                    tx_reg, tx_next;
   logic                    done;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg  <= ST_IDLE;
         tick_reg   <= '0;
         bit_reg    <= '0;
         shift_reg  <= '0;
         parity_reg <= 1'b0;
         tx_reg     <= 1'b1;
      end else begin
         state_reg  <= state_next;
         tick_reg   <= tick_next;
         bit_reg    <= bit_next;
         shift_reg  <= shift_next;
         parity_reg <= parity_next;
         tx_reg     <= tx_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      tick_next   = tick_reg;
      bit_next    = bit_reg;
      shift_next  = shift_reg;
      parity_next = parity_reg;
      done        = 1'b0;
      tx_next     = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            if (i_tx_start) begin
               shift_next  = i_tx_data;
               parity_next = (^i_tx_data) ^ ODD;
               tick_next   = '0;
               bit_next    = '0;
               state_next  = ST_START;
            end
         end
         ST_START: begin
            if (i_s_tick) begin
               if (tick_reg == BIT_LAST) begin
                  tick_next  = '0;
                  bit_next   = '0;
                  state_next = ST_DATA;
               end else begin
                  tick_next = tick_reg + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (i_s_tick) begin
               if (tick_reg == BIT_LAST) begin
                  tick_next  = '0;
                  shift_next = shift_reg >> 1;
                  if (bit_reg == DATA_LAST)
                     state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  else
                     bit_next = bit_reg + 1'b1;
               end else begin
                  tick_next = tick_reg + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (i_s_tick) begin
               if (tick_reg == BIT_LAST) begin
                  tick_next  = '0;
                  state_next = ST_STOP;
               end else begin
                  tick_next = tick_reg + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (i_s_tick) begin
               if (tick_reg == STOP_LAST) begin
                  tick_next  = '0;
                  done       = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  tick_next = tick_reg + 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Line level is derived from where the FSM is heading so it changes right after the deciding edge
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = shift_next[0];
         ST_PARITY: tx_next = parity_next;
         default:   tx_next = 1'b1;
      endcase
   end

   assign o_tx           = tx_reg;
   assign o_tx_busy      = (state_reg != ST_IDLE);
   assign o_tx_done_tick = done & ~i_reset;

endmodule
